// File: rtl/fwd_hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// fwd_hazard_ctrl_pkg
// Shared pipeline types for the forwarding / hazard control block.
//   NREG_W       : register-index width (x0 is hard-wired zero)
//   fwd_sel_t    : select encoding for the EX-stage 4:1 operand muxes
//   stage_tag_t  : shadow record of the instruction occupying EX
//   mem_tag_t    : reduced shadow record for the MEM stage
//   wb_tag_t     : reduced shadow record for the WB stage
// -----------------------------------------------------------------------------
package fwd_hazard_ctrl_pkg;

    localparam int NREG_W = 5;

    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwd_sel_t;

    typedef struct packed {
        logic              valid;
        logic [NREG_W-1:0] rs1;
        logic [NREG_W-1:0] rs2;
        logic              use_rs1;
        logic              use_rs2;
        logic [NREG_W-1:0] rd;
        logic              regwrite;
        logic              is_load;
    } stage_tag_t;

    typedef struct packed {
        logic              valid;
        logic [NREG_W-1:0] rd;
        logic              regwrite;
        logic              is_load;
    } mem_tag_t;

    typedef struct packed {
        logic              valid;
        logic [NREG_W-1:0] rd;
        logic              regwrite;
    } wb_tag_t;

endpackage

// File: rtl/fwd_hazard_ctrl_fwd_match.sv
// -----------------------------------------------------------------------------
// fwd_match
// Combinational tag comparator that picks the forwarding source for one
// EX-stage operand.
//   ex_use  : EX instruction actually reads this operand
//   ex_rs   : EX source register index for this operand
//   mem_tag : MEM shadow record
//   wb_tag  : WB shadow record
//   sel     : operand mux select (FWD_RF / FWD_EXMEM / FWD_MEMWB)
// -----------------------------------------------------------------------------
module fwd_match
    import fwd_hazard_ctrl_pkg::*;
(
    input  logic              ex_use,
    input  logic [NREG_W-1:0] ex_rs,
    input  mem_tag_t          mem_tag,
    input  wb_tag_t           wb_tag,
    output fwd_sel_t          sel
);

    logic operand_live;
    logic mem_hit;
    logic wb_hit;

    // A load in MEM has no data yet, so it is never a forwarding source;
    // the load-use stall guarantees the consumer meets it in WB instead.
    // MEM is checked first so the youngest producer wins a double match.
    always_comb begin
        operand_live = ex_use && (ex_rs != '0);
        mem_hit      = operand_live && mem_tag.valid && mem_tag.regwrite &&
                       !mem_tag.is_load && (mem_tag.rd == ex_rs);
        wb_hit       = operand_live && wb_tag.valid && wb_tag.regwrite &&
                       (wb_tag.rd == ex_rs);
        sel          = FWD_RF;
        if (mem_hit) begin
            sel = FWD_EXMEM;
        end else if (wb_hit) begin
            sel = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// fwd_hazard_ctrl
// Control-side companion of the pipeline operand muxes. Keeps shadow copies of
// the register tags in EX/MEM/WB, produces the EX forwarding selects and the
// stall / bubble / flush / freeze controls, and counts stall cycles.
//   clk, rst          : clock, synchronous active-high reset
//   id_*              : tags of the instruction currently in ID
//   dmem_stall        : data memory not ready, freeze the whole pipe
//   ex_flush          : taken branch/jump resolved in EX this cycle
//   fwd_a_sel/_b_sel  : EX operand mux selects
//   hold_if_id        : hold PC and IF/ID
//   bubble_ex         : load a NOP into ID/EX
//   flush_if_id       : invalidate IF/ID
//   freeze_all        : hold every pipeline register
//   stall_cnt         : cycles with hold_if_id asserted (wraps)
// -----------------------------------------------------------------------------
module fwd_hazard_ctrl #(
    parameter int NREG_W = fwd_hazard_ctrl_pkg::NREG_W,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [NREG_W-1:0] id_rs1,
    input  logic [NREG_W-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [NREG_W-1:0] id_rd,
    input  logic              id_regwrite,
    input  logic              id_is_load,
    input  logic              dmem_stall,
    input  logic              ex_flush,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic              hold_if_id,
    output logic              bubble_ex,
    output logic              flush_if_id,
    output logic              freeze_all,
    output logic [CNT_W-1:0]  stall_cnt
);

    import fwd_hazard_ctrl_pkg::*;

    stage_tag_t       ex_q, ex_d;
    mem_tag_t         mem_q, mem_d;
    wb_tag_t          wb_q, wb_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    fwd_sel_t sel_a;
    fwd_sel_t sel_b;
    logic     load_use;

    fwd_match u_match_a (
        .ex_use  (ex_q.use_rs1),
        .ex_rs   (ex_q.rs1),
        .mem_tag (mem_q),
        .wb_tag  (wb_q),
        .sel     (sel_a)
    );

    fwd_match u_match_b (
        .ex_use  (ex_q.use_rs2),
        .ex_rs   (ex_q.rs2),
        .mem_tag (mem_q),
        .wb_tag  (wb_q),
        .sel     (sel_b)
    );

    assign fwd_a_sel = sel_a;
    assign fwd_b_sel = sel_b;
    assign stall_cnt = stall_cnt_q;

    // Load-use hazard: a load in EX whose result the ID instruction needs
    // cannot be forwarded in time, so the consumer must wait one cycle.
    always_comb begin
        load_use = ex_q.valid && ex_q.is_load && ex_q.regwrite &&
                   (ex_q.rd != '0) && id_valid &&
                   ((id_use_rs1 && (id_rs1 == ex_q.rd)) ||
                    (id_use_rs2 && (id_rs2 == ex_q.rd)));
    end

    // Control priority: a memory stall freezes everything, a flush kills the
    // wrong-path ID instruction (making any load-use stall moot), and only
    // then does a load-use hazard hold the front end.
    always_comb begin
        freeze_all  = 1'b0;
        hold_if_id  = 1'b0;
        bubble_ex   = 1'b0;
        flush_if_id = 1'b0;
        if (dmem_stall) begin
            freeze_all  = 1'b1;
        end else if (ex_flush) begin
            flush_if_id = 1'b1;
            bubble_ex   = 1'b1;
        end else if (load_use) begin
            hold_if_id  = 1'b1;
            bubble_ex   = 1'b1;
        end
    end

    // Shadow pipeline advance; a frozen pipe keeps every record in place.
    always_comb begin
        ex_d        = ex_q;
        mem_d       = mem_q;
        wb_d        = wb_q;
        stall_cnt_d = stall_cnt_q;
        if (!dmem_stall) begin
            wb_d.valid     = mem_q.valid;
            wb_d.rd        = mem_q.rd;
            wb_d.regwrite  = mem_q.regwrite;

            mem_d.valid    = ex_q.valid;
            mem_d.rd       = ex_q.rd;
            mem_d.regwrite = ex_q.regwrite;
            mem_d.is_load  = ex_q.is_load;

            ex_d.valid     = id_valid && !bubble_ex;
            ex_d.rs1       = id_rs1;
            ex_d.rs2       = id_rs2;
            ex_d.use_rs1   = id_use_rs1;
            ex_d.use_rs2   = id_use_rs2;
            ex_d.rd        = id_rd;
            ex_d.regwrite  = id_regwrite;
            ex_d.is_load   = id_is_load;
        end
        if (hold_if_id) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            stall_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= mem_d;
            wb_q        <= wb_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fwd_hazard_ctrl
// Directed bench for fwd_hazard_ctrl: walks short instruction sequences
// through ID and compares forwarding selects, pipeline controls and the
// stall counter against hand-computed values.
// -----------------------------------------------------------------------------
module tb_fwd_hazard_ctrl;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_use_rs1;
    logic        id_use_rs2;
    logic [4:0]  id_rd;
    logic        id_regwrite;
    logic        id_is_load;
    logic        dmem_stall;
    logic        ex_flush;
    logic [1:0]  fwd_a_sel;
    logic [1:0]  fwd_b_sel;
    logic        hold_if_id;
    logic        bubble_ex;
    logic        flush_if_id;
    logic        freeze_all;
    logic [31:0] stall_cnt;

    int checks;
    int failures;

    fwd_hazard_ctrl #(
        .NREG_W (5),
        .CNT_W  (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .id_rd       (id_rd),
        .id_regwrite (id_regwrite),
        .id_is_load  (id_is_load),
        .dmem_stall  (dmem_stall),
        .ex_flush    (ex_flush),
        .fwd_a_sel   (fwd_a_sel),
        .fwd_b_sel   (fwd_b_sel),
        .hold_if_id  (hold_if_id),
        .bubble_ex   (bubble_ex),
        .flush_if_id (flush_if_id),
        .freeze_all  (freeze_all),
        .stall_cnt   (stall_cnt)
    );

    // Free-running clock, period 10
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive the ID-stage instruction tags
    task automatic applyStimulus(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic u1, input logic u2, input logic [4:0] rd,
                                 input logic rw, input logic ld);
        id_valid    = v;
        id_rs1      = rs1;
        id_rs2      = rs2;
        id_use_rs1  = u1;
        id_use_rs2  = u2;
        id_rd       = rd;
        id_regwrite = rw;
        id_is_load  = ld;
    endtask

    task automatic applyNop();
        applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    // Advance one clock and settle just after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare every control output against expectations
    task automatic checkOutput(input string tag, input logic [1:0] exp_a, input logic [1:0] exp_b,
                               input logic exp_hold, input logic exp_bub,
                               input logic exp_flush, input logic exp_freeze);
        #1;
        checks++;
        assert (fwd_a_sel === exp_a) else begin
            failures++;
            $error("[TB] FAIL %s fwd_a_sel observed=%b expected=%b", tag, fwd_a_sel, exp_a);
        end
        checks++;
        assert (fwd_b_sel === exp_b) else begin
            failures++;
            $error("[TB] FAIL %s fwd_b_sel observed=%b expected=%b", tag, fwd_b_sel, exp_b);
        end
        checks++;
        assert (hold_if_id === exp_hold) else begin
            failures++;
            $error("[TB] FAIL %s hold_if_id observed=%b expected=%b", tag, hold_if_id, exp_hold);
        end
        checks++;
        assert (bubble_ex === exp_bub) else begin
            failures++;
            $error("[TB] FAIL %s bubble_ex observed=%b expected=%b", tag, bubble_ex, exp_bub);
        end
        checks++;
        assert (flush_if_id === exp_flush) else begin
            failures++;
            $error("[TB] FAIL %s flush_if_id observed=%b expected=%b", tag, flush_if_id, exp_flush);
        end
        checks++;
        assert (freeze_all === exp_freeze) else begin
            failures++;
            $error("[TB] FAIL %s freeze_all observed=%b expected=%b", tag, freeze_all, exp_freeze);
        end
    endtask

    task automatic checkCount(input string tag, input logic [31:0] exp_cnt);
        checks++;
        assert (stall_cnt === exp_cnt) else begin
            failures++;
            $error("[TB] FAIL %s stall_cnt observed=%0d expected=%0d", tag, stall_cnt, exp_cnt);
        end
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        rst        = 1'b1;
        dmem_stall = 1'b0;
        ex_flush   = 1'b0;
        applyNop();
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        checkOutput("reset", 2'b00, 2'b00, 0, 0, 0, 0);
        checkCount("reset", 32'd0);

        // add x1 ; add x2,x1,x3 back-to-back
        applyStimulus(1, 5'd2, 5'd3, 1, 1, 5'd1, 1, 0);
        checkOutput("t1_prod", 2'b00, 2'b00, 0, 0, 0, 0);
        tick();
        applyStimulus(1, 5'd1, 5'd3, 1, 1, 5'd2, 1, 0);
        checkOutput("t1_cons_id", 2'b00, 2'b00, 0, 0, 0, 0);
        tick();
        applyNop();
        checkOutput("t1_cons_ex", 2'b01, 2'b00, 0, 0, 0, 0);
        checkCount("t1_cnt", 32'd0);
        tick();

        // add x1 ; nop ; sub x4,x3,x1
        applyStimulus(1, 5'd5, 5'd6, 1, 1, 5'd1, 1, 0);
        checkOutput("t2_prod", 2'b00, 2'b00, 0, 0, 0, 0);
        tick();
        applyNop();
        checkOutput("t2_nop", 2'b00, 2'b00, 0, 0, 0, 0);
        tick();
        applyStimulus(1, 5'd3, 5'd1, 1, 1, 5'd4, 1, 0);
        checkOutput("t2_sub_id", 2'b00, 2'b00, 0, 0, 0, 0);
        tick();
        // sub in EX, add x1 in WB; also issue first of two x1 writers
        applyStimulus(1, 5'd7, 5'd8, 1, 1, 5'd1, 1, 0);
        checkOutput("t2_sub_ex", 2'b00, 2'b10, 0, 0, 0, 0);
        tick();
        applyStimulus(1, 5'd7, 5'd8, 1, 1, 5'd1, 1, 0);
        checkOutput("t2_w2", 2'b00, 2'b00, 0, 0, 0, 0);
        tick();
        applyStimulus(1, 5'd1, 5'd1, 1, 1, 5'd9, 1, 0);
        checkOutput("t2_dbl_id", 2'b00, 2'b00, 0, 0, 0, 0);
        tick();
        applyNop();
        checkOutput("t2_dbl_ex", 2'b01, 2'b01, 0, 0, 0, 0);
        tick();

        // lw x5 ; add x6,x5,x5
        applyStimulus(1, 5'd10, 5'd0, 1, 0, 5'd5, 1, 1);
        checkOutput("t3_lw", 2'b00, 2'b00, 0, 0, 0, 0);
        tick();
        applyStimulus(1, 5'd5, 5'd5, 1, 1, 5'd6, 1, 0);
        checkOutput("t3_lu", 2'b00, 2'b00, 1, 1, 0, 0);
        checkCount("t3_cnt0", 32'd0);
        tick();
        checkOutput("t3_bubble", 2'b00, 2'b00, 0, 0, 0, 0);
        checkCount("t3_cnt1", 32'd1);
        tick();
        applyNop();
        checkOutput("t3_cons_ex", 2'b10, 2'b10, 0, 0, 0, 0);
        tick();

        // lw x5 in EX, consumer in ID, flush in the same cycle
        applyStimulus(1, 5'd10, 5'd0, 1, 0, 5'd5, 1, 1);
        checkOutput("t4_lw", 2'b00, 2'b00, 0, 0, 0, 0);
        tick();
        applyStimulus(1, 5'd5, 5'd5, 1, 1, 5'd6, 1, 0);
        ex_flush = 1'b1;
        checkOutput("t4_flush", 2'b00, 2'b00, 0, 1, 1, 0);
        tick();
        ex_flush = 1'b0;
        applyNop();
        checkOutput("t4_after", 2'b00, 2'b00, 0, 0, 0, 0);
        checkCount("t4_cnt", 32'd1);
        tick();

        // dmem_stall held 3 cycles during a load-use hazard
        applyStimulus(1, 5'd11, 5'd0, 1, 0, 5'd7, 1, 1);
        checkOutput("t5_lw", 2'b00, 2'b00, 0, 0, 0, 0);
        tick();
        applyStimulus(1, 5'd7, 5'd2, 1, 1, 5'd8, 1, 0);
        dmem_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checkOutput("t5_freeze", 2'b00, 2'b00, 0, 0, 0, 1);
            checkCount("t5_cnt_frz", 32'd1);
            tick();
        end
        dmem_stall = 1'b0;
        checkOutput("t5_release", 2'b00, 2'b00, 1, 1, 0, 0);
        tick();
        checkOutput("t5_bubble", 2'b00, 2'b00, 0, 0, 0, 0);
        checkCount("t5_cnt", 32'd2);
        tick();
        applyNop();
        checkOutput("t5_cons_ex", 2'b10, 2'b00, 0, 0, 0, 0);
        tick();

        // Writes to x0 then consumers of x0
        applyStimulus(1, 5'd3, 5'd4, 1, 1, 5'd0, 1, 0);
        checkOutput("t6_add_x0", 2'b00, 2'b00, 0, 0, 0, 0);
        tick();
        applyStimulus(1, 5'd12, 5'd0, 1, 0, 5'd0, 1, 1);
        checkOutput("t6_lw_x0", 2'b00, 2'b00, 0, 0, 0, 0);
        tick();
        applyStimulus(1, 5'd0, 5'd0, 1, 1, 5'd9, 1, 0);
        checkOutput("t6_x0_nolu", 2'b00, 2'b00, 0, 0, 0, 0);
        tick();
        applyNop();
        checkOutput("t6_x0_nofwd", 2'b00, 2'b00, 0, 0, 0, 0);
        checkCount("t6_cnt", 32'd2);
        tick();

        // Reset asserted while a load-use stall is pending
        applyStimulus(1, 5'd10, 5'd0, 1, 0, 5'd5, 1, 1);
        tick();
        applyStimulus(1, 5'd5, 5'd5, 1, 1, 5'd6, 1, 0);
        checkOutput("t7_pending", 2'b00, 2'b00, 1, 1, 0, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("t7_post_rst", 2'b00, 2'b00, 0, 0, 0, 0);
        checkCount("t7_cnt", 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time limit so the run always ends
    initial begin
        #100000;
        $display("[TB] FAIL timeout observed=running expected=finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
